// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter driving a 4-bit LCD bus through SETUP / E_HIGH / E_LOW phases.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module lcd_bus_arbiter #(
    parameter int unsigned STEP_CYCLES = 32'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [5:0] req0_word,
    input  logic [5:0] req1_word,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       req0_done,
    output logic       req1_done,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_W,
    output logic       LCD_E,
    output logic       lcd3,
    output logic       lcd2,
    output logic       lcd1,
    output logic       lcd0
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] E_HIGH = 2'd2;
    localparam logic [1:0] E_LOW  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  bus_q, bus_d;
    logic        e_q, e_d;
    logic        owner_q, owner_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        grant1;
    logic        accept;
    logic        phase_end;

`ifdef LCD_ARB_FIXED_PRIO_EN
    always_comb grant1 = req1_valid && !req0_valid;
`else
    // last_q = 1 means requester 1 owned the previous transfer, so requester 0 wins a tie.
    logic last_q, last_d;
    always_comb grant1 = req1_valid && (!req0_valid || !last_q);
`endif

    always_comb begin
        accept     = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
        req0_ready = accept && !grant1;
        req1_ready = accept && grant1;
        phase_end  = (cnt_q == STEP_CYCLES - 32'd1);
    end

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        e_d     = e_q;
        owner_d = owner_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        if (state_q == IDLE) begin
            if (req0_ready || req1_ready) begin
                state_d = SETUP;
                cnt_d   = 32'd0;
                bus_d   = req1_ready ? req1_word : req0_word;
                e_d     = 1'b0;
                owner_d = req1_ready;
`ifndef LCD_ARB_FIXED_PRIO_EN
                last_d  = req1_ready;
`endif
            end
        end else if (phase_end) begin
            cnt_d = 32'd0;
            case (state_q)
                SETUP:  begin state_d = E_HIGH; e_d = 1'b1; end
                E_HIGH: begin state_d = E_LOW;  e_d = 1'b0; end
                default: begin
                    state_d = IDLE;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                end
            endcase
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            bus_q   <= 6'd0;
            e_q     <= 1'b0;
            owner_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            e_q     <= e_d;
            owner_q <= owner_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifndef LCD_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        req0_done = done0_q;
        req1_done = done1_q;
        LCD_E     = e_q;
        {LCD_RS, LCD_W, lcd3, lcd2, lcd1, lcd0} = bus_q;
    end

endmodule
